ex_issue_stage: RTL and testbench

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/operand_fwd_mux.sv | 25 ++
 rtl/ex_issue_stage.sv | 100 ++++++++++
 tb/tb_ex_issue_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 opcode constants, the EX-slot control record and its bubble encoding.
// Also holds the bypass-match helper used by the operand forwarding muxes.
package rv32_pkg;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] STORE_OP = 7'b0100011;

  typedef struct packed {
    logic       valid;
    logic [6:0] op;
    logic [6:0] op_2;
    logic [2:0] func;
    logic       sub_en;
    logic       use_imm;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd;
  } ex_ctrl_t;

  // A bubble is an invalid slot carrying the canonical NOP opcode (addi x0, x0, 0).
  localparam ex_ctrl_t BUBBLE = '{
    valid:    1'b0,
    op:       OP_IMM,
    op_2:     7'd0,
    func:     3'd0,
    sub_en:   1'b0,
    use_imm:  1'b0,
    rs1_addr: 5'd0,
    rs2_addr: 5'd0,
    rd:       5'd0
  };

  function automatic logic fwd_hit(input logic wen, input logic [4:0] rd, input logic [4:0] rs);
    return wen && (rd == rs) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Bypass selector for one source operand: the younger EX/MEM result wins over MEM/WB,
// and the stored register-file value is used when neither matches. x0 never forwards.
module operand_fwd_mux
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_addr,
  input  logic [XLEN-1:0] stored,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = stored;
    if (fwd_hit(wb_wen, wb_rd, rs_addr)) data = wb_result;
    if (fwd_hit(mem_wen, mem_rd, rs_addr)) data = mem_result;
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline slot: registers the decoded instruction, forwards operands from MEM/WB,
// and flags load-use hazards back to decode.
module ex_issue_stage
  import rv32_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter logic [6:0] LOAD_OP = rv32_pkg::LOAD_OP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [6:0]      id_op,
  input  logic [6:0]      id_op_2,
  input  logic [2:0]      id_func,
  input  logic            id_sub_en,
  input  logic            id_use_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [6:0]      ex_op,
  output logic [6:0]      ex_op_2,
  output logic [2:0]      ex_func,
  output logic            ex_sub_en,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_din1,
  output logic [XLEN-1:0] ex_din2,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard
);

  ex_ctrl_t        ctrl;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr(ctrl.rs1_addr), .stored(rs1_q),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rs1_fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr(ctrl.rs2_addr), .stored(rs2_q),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rs2_fwd)
  );

  // While stalled, the stored operands track the bypass so a producer leaving WB is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ctrl  <= BUBBLE;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (stall) begin
      rs1_q <= rs1_fwd;
      rs2_q <= rs2_fwd;
    end else begin
      ctrl.valid    <= id_valid;
      ctrl.op       <= id_op;
      ctrl.op_2     <= id_op_2;
      ctrl.func     <= id_func;
      ctrl.sub_en   <= id_sub_en;
      ctrl.use_imm  <= id_use_imm;
      ctrl.rs1_addr <= id_rs1_addr;
      ctrl.rs2_addr <= id_rs2_addr;
      ctrl.rd       <= id_rd_addr;
      rs1_q         <= id_rs1_data;
      rs2_q         <= id_rs2_data;
      imm_q         <= id_imm;
    end
  end

  assign ex_valid      = ctrl.valid;
  assign ex_op         = ctrl.op;
  assign ex_op_2       = ctrl.op_2;
  assign ex_func       = ctrl.func;
  assign ex_sub_en     = ctrl.sub_en;
  assign ex_rd         = ctrl.rd;
  assign ex_din1       = rs1_fwd;
  assign ex_din2       = ctrl.use_imm ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;

  assign load_use_hazard = ctrl.valid && (ctrl.op == LOAD_OP) && (ctrl.rd != 5'd0) &&
                           ((ctrl.rd == id_rs1_addr) || (ctrl.rd == id_rs2_addr)) && id_valid;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX slot.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_sub_en, id_use_imm, stall, flush, mem_wen, wb_wen;
  logic [6:0]  id_op, id_op_2;
  logic [2:0]  id_func;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd, wb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic        ex_valid, ex_sub_en, load_use_hazard;
  logic [6:0]  ex_op, ex_op_2;
  logic [2:0]  ex_func;
  logic [4:0]  ex_rd;
  logic [31:0] ex_din1, ex_din2, ex_store_data;

  int n_chk  = 0;
  int n_pass = 0;

  // model of the instruction sitting in EX
  logic        m_valid, m_sub, m_use_imm;
  logic [6:0]  m_op, m_op2;
  logic [2:0]  m_func;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;

  ex_issue_stage #(.XLEN(32), .LOAD_OP(7'b0000011)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_op_2(id_op_2),
    .id_func(id_func), .id_sub_en(id_sub_en), .id_use_imm(id_use_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .stall(stall), .flush(flush), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_op_2(ex_op_2), .ex_func(ex_func),
    .ex_sub_en(ex_sub_en), .ex_rd(ex_rd), .ex_din1(ex_din1), .ex_din2(ex_din2),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs == 0) return stored;
    if (mem_wen && mem_rd == rs) return mem_result;
    if (wb_wen && wb_rd == rs) return wb_result;
    return stored;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_op = 7'b0010011; m_op2 = 0; m_func = 0; m_sub = 0; m_use_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
  endtask

  task automatic check_all();
    logic [31:0] f1, f2;
    logic        haz;
    f1  = fwd(m_rs1, m_d1);
    f2  = fwd(m_rs2, m_d2);
    haz = m_valid && m_op == 7'b0000011 && m_rd != 0 &&
          (m_rd == id_rs1_addr || m_rd == id_rs2_addr) && id_valid;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_op", 32'(ex_op), 32'(m_op));
    chk("ex_op_2", 32'(ex_op_2), 32'(m_op2));
    chk("ex_func", 32'(ex_func), 32'(m_func));
    chk("ex_sub_en", 32'(ex_sub_en), 32'(m_sub));
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("ex_din1", ex_din1, f1);
    chk("ex_din2", ex_din2, m_use_imm ? m_imm : f2);
    chk("ex_store_data", ex_store_data, f2);
    chk("load_use_hazard", 32'(load_use_hazard), 32'(haz));
  endtask

  // Checks outputs with current inputs, clocks once, updates the model, returns at negedge.
  task automatic step();
    logic [31:0] f1, f2;
    #1;
    check_all();
    f1 = fwd(m_rs1, m_d1);
    f2 = fwd(m_rs2, m_d2);
    @(posedge clk);
    if (rst || flush) model_bubble();
    else if (stall) begin
      m_d1 = f1; m_d2 = f2;
    end else begin
      m_valid = id_valid; m_op = id_op; m_op2 = id_op_2; m_func = id_func;
      m_sub = id_sub_en; m_use_imm = id_use_imm; m_rs1 = id_rs1_addr;
      m_rs2 = id_rs2_addr; m_rd = id_rd_addr; m_d1 = id_rs1_data;
      m_d2 = id_rs2_data; m_imm = id_imm;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_op = 0; id_op_2 = 0; id_func = 0; id_sub_en = 0; id_use_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; stall = 0; flush = 0; mem_wen = 0; mem_rd = 0; mem_result = 0;
    wb_wen = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    idle_inputs();
    id_valid = 1; id_op = op; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_bubble();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("reset_op", 32'(ex_op), 32'h13);
    rst = 0;

    // capture
    issue(7'b0110011, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7);
    step();
    idle_inputs();
    #1;
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_din1", ex_din1, 32'd5);
    chk("cap_din2", ex_din2, 32'd7);

    // forward priority on rs1=x3
    issue(7'b0110011, 5'd3, 5'd2, 5'd6, 32'd1, 32'd9);
    step();
    idle_inputs();
    stall = 1;
    mem_wen = 1; mem_rd = 3; mem_result = 32'hAA;
    wb_wen = 1; wb_rd = 3; wb_result = 32'hBB;
    #1;
    chk("fwd_mem_first", ex_din1, 32'hAA);
    mem_wen = 0;
    #1;
    chk("fwd_wb_second", ex_din1, 32'hBB);
    step();
    issue(7'b0110011, 5'd0, 5'd2, 5'd6, 32'h77, 32'd9);
    step();
    idle_inputs();
    mem_wen = 1; mem_rd = 0; mem_result = 32'hAA;
    wb_wen = 1; wb_rd = 0; wb_result = 32'hBB;
    #1;
    chk("fwd_x0_stored", ex_din1, 32'h77);
    step();

    // stall refresh on rs2=x5
    issue(7'b0110011, 5'd1, 5'd5, 5'd6, 32'd1, 32'h11);
    step();
    idle_inputs();
    stall = 1; wb_wen = 1; wb_rd = 5; wb_result = 32'h55;
    step();
    wb_wen = 0;
    step();
    stall = 0;
    #1;
    chk("stall_refresh_din2", ex_din2, 32'h55);
    step();

    // load-use
    issue(7'b0000011, 5'd1, 5'd2, 5'd4, 32'd0, 32'd0);
    step();
    idle_inputs();
    id_valid = 1; id_rs2_addr = 4;
    #1;
    chk("load_use_hit", 32'(load_use_hazard), 32'd1);
    issue(7'b0000011, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step();
    idle_inputs();
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 0;
    #1;
    chk("load_use_rd0", 32'(load_use_hazard), 32'd0);
    step();

    // flush overrides stall
    issue(7'b0110011, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4);
    step();
    idle_inputs();
    flush = 1; stall = 1;
    step();
    idle_inputs();
    #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_op", 32'(ex_op), 32'h13);

    // async reset between edges
    issue(7'b0110011, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4);
    step();
    idle_inputs();
    stall = 1;
    #2;
    rst = 1;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_din1", ex_din1, 32'd0);
    model_bubble();
    step();
    rst = 0;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [5];
      ops[0] = 7'b0000011; ops[1] = 7'b0010011; ops[2] = 7'b0110011;
      ops[3] = 7'b0100011; ops[4] = 7'($urandom);
      id_valid    = 1'($urandom_range(0, 3) != 0);
      id_op       = ops[$urandom_range(0, 4)];
      id_op_2     = 7'($urandom);
      id_func     = 3'($urandom);
      id_sub_en   = 1'($urandom);
      id_use_imm  = 1'($urandom);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      stall       = 1'($urandom_range(0, 3) == 0);
      flush       = 1'($urandom_range(0, 9) == 0);
      mem_wen     = 1'($urandom);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_result  = $urandom;
      wb_wen      = 1'($urandom);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_result   = $urandom;
      rst         = 1'($urandom_range(0, 49) == 0);
      if (rst) model_bubble();
      step();
      rst = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
